// File: rtl/pipe_stage_elastic_if.sv
// Stream handshake bundle: valid/ready plus opaque payload and control fields.
// The master drives valid/data/ctrl; the slave answers with ready.
interface pipe_stage_elastic_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input  ready);
  modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline register: head entry plus optional skid entry, flush-to-NOP, bubble counter.
// Latency 1 cycle; with SKID=1 in_ready comes straight from a flop, with SKID=0 it is combinational.
module pipe_stage_elastic #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_flush,
  pipe_stage_elastic_if.slave  i_up,
  pipe_stage_elastic_if.master o_dn,
  output logic [1:0]           o_occupancy,
  output logic [CNT_W-1:0]     o_bubble_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_bubble;

  logic w_in_ready;
  logic w_accept;
  logic w_retire;
  logic w_head_free;

  always_comb begin
    if (SKID != 0) w_in_ready = !r_skid_valid;
    else           w_in_ready = !r_out_valid || o_dn.ready;
  end

  assign w_accept    = i_up.valid && w_in_ready;
  assign w_retire    = r_out_valid && o_dn.ready;
  assign w_head_free = !r_out_valid || w_retire;

  // The skid entry always drains into the head before new input can land there,
  // which keeps ordering strictly FIFO.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ctrl   <= CTRL_NOP;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= CTRL_NOP;
    end else if (w_head_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_ctrl   <= r_skid_ctrl;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_up.data;
        r_out_ctrl  <= i_up.ctrl;
      end else begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_ctrl  <= CTRL_NOP;
      end
    end else if (w_accept && (SKID != 0)) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_up.data;
      r_skid_ctrl  <= i_up.ctrl;
    end
  end

  // Flush deliberately leaves the counter alone so debug history survives pipeline redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble <= '0;
    end else if (!r_out_valid && (r_bubble != CNT_MAX)) begin
      r_bubble <= r_bubble + CNT_ONE;
    end
  end

  assign i_up.ready     = w_in_ready;
  assign o_dn.valid     = r_out_valid;
  assign o_dn.data      = r_out_data;
  assign o_dn.ctrl      = r_out_ctrl;
  assign o_occupancy    = {r_out_valid & r_skid_valid, r_out_valid ^ r_skid_valid};
  assign o_bubble_count = r_bubble;

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, generic pipeline-stage register; successor to the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Carries an opaque DATA_W payload plus a CTRL_W control bundle between any two stages.
- Replaces global stall with a valid/ready handshake and an optional 2-entry skid buffer, so in_ready is fully registered.
- Supports synchronous flush-to-NOP and keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, width of the data payload (pc, operands, immediate, etc. concatenated by the instantiating stage).
- CTRL_W, 8, width of the control bundle.
- CTRL_NOP, 0, control value presented whenever the stage holds no valid entry. It must encode reg_write=0, mem_read=0, mem_write=0.
- SKID, 1, selects the buffer mode:
  - 1: 2-entry skid buffer with registered in_ready.
  - 0: single entry with combinational in_ready.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous; discards all held entries and any input accepted in the same cycle.
- in_valid, input, 1, upstream has an entry.
- in_ready, output, 1, stage can accept an entry this cycle.
- in_data, input, DATA_W, upstream payload.
- in_ctrl, input, CTRL_W, upstream control bundle.
- out_valid, output, 1, stage presents a valid entry.
- out_ready, input, 1, downstream accepts this cycle.
- out_data, output, DATA_W, head payload.
- out_ctrl, output, CTRL_W, head control bundle.
- occupancy, output, 2, number of held entries: 0 to 2, or 0 to 1 when SKID=0.
- bubble_count, output, CNT_W, saturating count of cycles with out_valid=0.

Behaviour:
- Definitions: accept = in_valid & in_ready; retire = out_valid & out_ready.
- Reset (checked at clk edge while reset=1):
  - out_valid=0, out_data=0, out_ctrl=CTRL_NOP, occupancy=0, bubble_count=0.
  - Skid entry is invalid.
  - in_ready: 1 for SKID=1; per the SKID=0 formula (i.e. 1) for SKID=0.
- Priority: reset > flush > normal operation.
- Flush:
  - Next cycle: out_valid=0, skid entry invalid, out_data=0, out_ctrl=CTRL_NOP, occupancy=0.
  - Any accept in the flush cycle is dropped; upstream must treat it as consumed.
  - bubble_count is not cleared by flush.
- Latency: an entry accepted into an empty stage appears on out_* the next cycle. Throughput is 1 entry/cycle when out_ready is held high.
- SKID=1:
  - in_ready = !skid_valid, taken directly from a flop.
  - Head empty, or head retiring with skid empty: input loads the head.
  - Head valid and not retiring when input is accepted: input loads the skid entry.
  - Head retires while skid is valid: skid moves to head and the skid is cleared. No accept is possible that cycle, since in_ready=0.
  - Order is preserved strictly FIFO.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - No skid storage; occupancy never exceeds 1.
- NOP invariant: out_ctrl == CTRL_NOP whenever out_valid=0. On the cycle the head empties, out_ctrl is loaded with CTRL_NOP.
- Data hold: out_data and out_ctrl are stable while out_valid=1 and out_ready=0.
- Bubble counter:
  - Increments by 1 on each edge where out_valid=0 (reset inactive).
  - Saturates at 2^CNT_W-1 without wrapping.
- Simultaneous accept and retire, single entry held, skid empty: head takes the new entry and occupancy stays 1.
- Reset asserted mid-transfer: all entries are lost and no output glitches beyond the reset values.

Test Plan:
- Reset, then in_valid=1, in_data=0x00000010, in_ctrl=0x05, out_ready=1 → next cycle out_valid=1, out_data=0x10, out_ctrl=0x05; bubble_count=1 (the one empty cycle after reset).
- SKID=1: hold out_ready=0 and send 0xA, then 0xB → occupancy=2 and in_ready=0; 0xC is held off. Raise out_ready → outputs 0xA, 0xB, 0xC on consecutive cycles, and in_ready returns to 1 the cycle after 0xA retires.
- Flush with occupancy=2, in_valid=1 carrying 0xD in the same cycle → next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy=0. 0xD never appears on the output.
- Streaming with out_ready=1 and in_valid=1 for 8 cycles, data 1..8 → out_data 1..8 back-to-back; occupancy stays 1 and there are no bubbles after the first.
- CNT_W=4, idle for 20 cycles after reset → bubble_count saturates at 15. A subsequent flush leaves it at 15.
- SKID=0: out_valid=1 with out_ready=0 → in_ready=0 combinationally. Raise out_ready with in_valid=1 → accept and retire occur in the same cycle, occupancy stays 1.
